demux_1xn_stream: RTL and testbench
===================================

Name: demux_1xn_stream

Overview:
- Companion to the N:1 select mux: a 1-to-N stream distributor.
- Accepts one input word with a destination index and steers it into one of N output channels, or into all N channels in broadcast mode.
- Each channel has a one-entry registered slot with a valid/ready handshake.
- Routes ALU/memory results to multiple consumers (register file, compare unit, loop counter) in the sort/factorial/max datapath.

Parameters:
- N, 4, number of output channels; must be >= 2.
- WIDTH, 8, data width of each word.
- SEL_W, $clog2(N), select width. Derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  input word.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  1 = deliver to all channels; in_sel is ignored.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept this cycle (combinational).
- out_data  output  N*WIDTH  concatenated channel data; channel i = out_data[i*WIDTH +: WIDTH].
- out_valid  output  N  per-channel slot valid.
- out_ready  input  N  per-channel consumer ready.
- sel_err  output  1  registered one-cycle pulse: a unicast word with in_sel >= N was accepted and dropped.

Behaviour:
- State per channel: slot_valid[i] and slot_data[i]. out_valid[i] = slot_valid[i]; the out_data slice for channel i = slot_data[i].
- Transfers:
  - Input accept: in_valid && in_ready.
  - Channel i drain: out_valid[i] && out_ready[i].
- Slot availability: free[i] = !slot_valid[i] || out_ready[i]. A slot being drained can be reloaded in the same cycle.
- in_ready, combinational; in_valid must not depend on in_ready:
  - in_bcast=1: in_ready = AND of free[0..N-1].
  - in_bcast=0 and in_sel < N: in_ready = free[in_sel].
  - in_bcast=0 and in_sel >= N (only possible for non-power-of-two N): in_ready = 1.
- Slot load: channel i loads on an accept when (in_bcast || in_sel == i). It then sets slot_valid[i]=1 and slot_data[i]=in_data.
- Slot update, per channel each cycle:
  - load and drain: stays valid, takes the new data.
  - load only: becomes valid.
  - drain only: slot_valid clears; slot_data holds its last value.
  - neither: holds.
- Invalid select: an accept with in_bcast=0 and in_sel >= N loads no slot. sel_err = 1 on the following cycle, for exactly one cycle, then returns to 0. in_bcast=1 never raises sel_err.
- Latency: 1 cycle from accept to out_valid.
- Throughput: one word per cycle sustained when the target out_ready is held at 1.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Broadcast is all-or-nothing: no channel loads until every slot is free. It never partially delivers.
- Reset (rst_n=0), asynchronous, including mid-transfer: all slot_valid=0, all slot_data=0, sel_err=0. In-flight words are discarded. After release, in_ready = 1 whenever in_valid with a legal in_sel or bcast is presented.
- Must not deadlock: a stalled channel blocks only unicast to itself and broadcast; other channels keep accepting.

Decomposition:
- No shared package is required. SEL_W is a localparam. A shared package entry is justified only if another block reuses the channel-index type.
- Sub-module demux_slot: the one-entry register slot with load/drain/valid logic, WIDTH-parameterised. Instantiated N times in a generate loop.
- Top level holds the in_ready/free logic, the per-channel load decode and the sel_err register.

Test Plan (N=4, WIDTH=8 unless noted):
1. Assert rst_n=0 asynchronously while out_valid=4'b0110 -> immediately out_valid=0, out_data=0, sel_err=0. After release, unicast to ch0 is accepted on the first valid cycle.
2. out_ready=4'b1111; send 0xA5 with in_sel=2 -> next cycle out_valid=4'b0100 and out_data[23:16]=0xA5; the cycle after, out_valid=0.
3. out_ready[1]=0; send 0x11 to ch1, then 0x22 to ch1 -> second word sees in_ready=0 and stalls; 0x33 to ch0 is still accepted. Raise out_ready[1] -> 0x11 drains and 0x22 loads the same cycle.
4. Broadcast 0x5A while slot3 is valid and out_ready[3]=0 -> in_ready=0 and no channel loads. Raise out_ready[3] -> accept; next cycle out_valid=4'b1111, all slices 0x5A.
5. N=3: send in_sel=3, in_bcast=0 -> in_ready=1, no out_valid change, sel_err=1 for exactly one cycle.
6. out_ready all 1; 16 back-to-back words with in_sel cycling 0,1,2,3 -> 16 accepts in 16 cycles; each channel sees its 4 words in order, one per cycle of occupancy.

Source files
------------

// File: rtl/demux_1xn_stream_pkg.sv
// Shared helpers for the 1-to-N stream distributor.
// Contents:
//   sel_in_range - tells whether a destination index names an existing channel.
//                  With a non-power-of-two channel count, the select field can
//                  encode indices that have no channel behind them.
package demux_1xn_stream_pkg;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    logic ok;
    ok = (sel < n);
    return ok;
  endfunction

endpackage

// File: rtl/demux_1xn_stream_if.sv
// Stream bundle for the 1-to-N distributor: one input word with a destination
// index and a broadcast flag, plus N output channels that each carry their own
// valid/ready pair.
//   slave  - view used by the distributor (takes in_*, drives out_*).
//   master - view used by the producer/consumer side (a testbench or datapath).
// Signals:
//   in_data/in_sel/in_bcast/in_valid : input word, destination, broadcast, present
//   in_ready                         : distributor can take the word this cycle
//   out_data                         : channel i = out_data[i*WIDTH +: WIDTH]
//   out_valid/out_ready              : per-channel handshake
//   sel_err                          : one-cycle pulse after a dropped bad-index word
interface demux_1xn_stream_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(N);

  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_bcast;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic               sel_err;

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );
endinterface

// File: rtl/demux_1xn_stream_slot.sv
// One-entry registered channel slot.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : write data_i into the slot this cycle
//   data_i     : word to store
//   ready_i    : downstream consumer ready
//   valid_o    : slot holds a word (registered)
//   data_o     : stored word (registered; keeps its last value after a drain)
//   free_o     : slot can take a word this cycle (empty, or being drained now)
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             free_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state: a load wins over a drain, so a slot drained and reloaded in
  // the same cycle stays valid and takes the new word.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/demux_1xn_stream.sv
// 1-to-N stream distributor: steers each accepted word into the slot of the
// selected channel, or into every slot when broadcasting.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream bundle (slave view), see demux_1xn_stream_if
// A stalled channel only blocks unicast words to itself and broadcasts.
// Broadcast waits until every slot is free so it is never partially delivered.
module demux_1xn_stream
  import demux_1xn_stream_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_1xn_stream_if.slave   bus
);

  localparam int SEL_W = $clog2(N);
  localparam int NP    = 1 << SEL_W;

  logic [N-1:0]       free_s;
  logic [NP-1:0]      free_pad_s;
  logic [N-1:0]       load_s;
  logic [N-1:0]       valid_s;
  logic [N*WIDTH-1:0] data_s;
  logic               sel_ok_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               sel_err_q, sel_err_d;

  // Padded so that indexing with an out-of-range select stays inside the vector.
  assign free_pad_s = NP'(free_s);
  assign sel_ok_s   = sel_in_range(32'(bus.in_sel), N);

  // Input ready: broadcast needs every slot, unicast only its target slot;
  // a word with a nonexistent target is always taken so it can be dropped.
  always_comb begin
    in_ready_s = 1'b0;
    if (bus.in_bcast) begin
      in_ready_s = &free_s;
    end else if (sel_ok_s) begin
      in_ready_s = free_pad_s[bus.in_sel];
    end else begin
      in_ready_s = 1'b1;
    end
  end

  assign accept_s = bus.in_valid && in_ready_s;

  for (genvar i = 0; i < N; i++) begin : g_slot
    assign load_s[i] = accept_s && (bus.in_bcast || (bus.in_sel == SEL_W'(i)));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load_s[i]),
      .data_i  (bus.in_data),
      .ready_i (bus.out_ready[i]),
      .valid_o (valid_s[i]),
      .data_o  (data_s[i*WIDTH +: WIDTH]),
      .free_o  (free_s[i])
    );
  end

  // A unicast word aimed at a nonexistent channel is dropped and flagged.
  always_comb begin
    sel_err_d = accept_s && !bus.in_bcast && !sel_ok_s;
  end

  // Error pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_s;
  assign bus.out_data  = data_s;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux_1xn_stream.sv
module tb_demux_1xn_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_1xn_stream_if #(.N(4), .WIDTH(8)) if4 ();
  demux_1xn_stream_if #(.N(3), .WIDTH(8)) if3 ();

  demux_1xn_stream #(.N(4), .WIDTH(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  demux_1xn_stream #(.N(3), .WIDTH(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model for the N=4 instance: per-channel queue of words the
  // consumer has yet to receive (at most one, since each slot holds one).
  logic [7:0] mq[4][$];
  logic       exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle on the N=4 instance; called at posedge+1.
  task automatic cyc4(input logic [7:0] d, input logic [1:0] s, input logic b,
                      input logic v, input logic [3:0] r,
                      output logic ir, output logic [3:0] ov);
    logic [3:0] fr;
    logic       er;
    logic       acc;
    if4.in_data   = d;
    if4.in_sel    = s;
    if4.in_bcast  = b;
    if4.in_valid  = v;
    if4.out_ready = r;
    for (int c = 0; c < 4; c++) fr[c] = (mq[c].size() == 0) || r[c];
    er = b ? (&fr) : fr[s];
    @(negedge clk);
    ir = if4.in_ready;
    ov = if4.out_valid;
    chk("in_ready", {31'd0, ir}, {31'd0, er});
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("out_valid[%0d]", c), {31'd0, ov[c]}, {31'd0, mq[c].size() != 0});
      if (mq[c].size() != 0)
        chk($sformatf("out_data[%0d]", c), {24'd0, if4.out_data[c*8 +: 8]}, {24'd0, mq[c][0]});
    end
    chk("sel_err", {31'd0, if4.sel_err}, {31'd0, exp_err});
    acc = v && er;
    for (int c = 0; c < 4; c++) begin
      if (mq[c].size() != 0 && r[c]) void'(mq[c].pop_front());
    end
    for (int c = 0; c < 4; c++) begin
      if (acc && (b || (s == 2'(c)))) mq[c].push_back(d);
    end
    exp_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       ir;
    logic [3:0] ov;
    int         n_acc;

    if4.in_data = 8'd0; if4.in_sel = 2'd0; if4.in_bcast = 1'b0;
    if4.in_valid = 1'b0; if4.out_ready = 4'd0;
    if3.in_data = 8'd0; if3.in_sel = 2'd0; if3.in_bcast = 1'b0;
    if3.in_valid = 1'b0; if3.out_ready = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset during activity: load ch1 and ch2 with consumers stalled.
    cyc4(8'h66, 2'd1, 1'b0, 1'b1, 4'b0000, ir, ov);
    cyc4(8'h99, 2'd2, 1'b0, 1'b1, 4'b0000, ir, ov);
    if4.in_valid = 1'b0;
    #2;
    chk("pre_reset_valid", {28'd0, if4.out_valid}, 32'h6);
    rst_n = 1'b0;
    #1;
    chk("reset_valid", {28'd0, if4.out_valid}, 32'h0);
    chk("reset_data", if4.out_data, 32'h0);
    chk("reset_sel_err", {31'd0, if4.sel_err}, 32'h0);
    for (int c = 0; c < 4; c++) mq[c].delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc4(8'h3C, 2'd0, 1'b0, 1'b1, 4'b1111, ir, ov);
    chk("post_reset_accept", {31'd0, ir}, 32'h1);
    cyc4(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, ir, ov);

    // Single unicast with 1-cycle latency.
    cyc4(8'hA5, 2'd2, 1'b0, 1'b1, 4'b1111, ir, ov);
    cyc4(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, ir, ov);
    chk("uni_valid", {28'd0, ov}, 32'h4);
    chk("uni_data", {24'd0, if4.out_data[23:16]}, 32'hA5);
    cyc4(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, ir, ov);
    chk("uni_drained", {28'd0, ov}, 32'h0);

    // Stall on ch1 does not block ch0; drain and reload in the same cycle.
    cyc4(8'h11, 2'd1, 1'b0, 1'b1, 4'b1101, ir, ov);
    cyc4(8'h22, 2'd1, 1'b0, 1'b1, 4'b1101, ir, ov);
    chk("stall_ch1", {31'd0, ir}, 32'h0);
    cyc4(8'h33, 2'd0, 1'b0, 1'b1, 4'b1101, ir, ov);
    chk("ch0_while_stall", {31'd0, ir}, 32'h1);
    cyc4(8'h22, 2'd1, 1'b0, 1'b1, 4'b1111, ir, ov);
    chk("reload_ch1", {31'd0, ir}, 32'h1);
    cyc4(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, ir, ov);
    chk("reload_data", {24'd0, if4.out_data[15:8]}, 32'h22);

    // Broadcast blocked by a stalled slot, then delivered everywhere.
    cyc4(8'h77, 2'd3, 1'b0, 1'b1, 4'b0111, ir, ov);
    cyc4(8'h5A, 2'd0, 1'b1, 1'b1, 4'b0111, ir, ov);
    chk("bcast_blocked", {31'd0, ir}, 32'h0);
    cyc4(8'h5A, 2'd1, 1'b1, 1'b1, 4'b1111, ir, ov);
    chk("bcast_accept", {31'd0, ir}, 32'h1);
    cyc4(8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, ir, ov);
    chk("bcast_valid", {28'd0, ov}, 32'hF);
    chk("bcast_data", if4.out_data, 32'h5A5A5A5A);
    cyc4(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, ir, ov);

    // Sustained throughput: 16 words cycling over the channels.
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      cyc4(8'(8'h80 + i), 2'(i % 4), 1'b0, 1'b1, 4'b1111, ir, ov);
      if (ir) n_acc++;
    end
    chk("burst_accepts", n_acc, 32'd16);
    cyc4(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, ir, ov);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc4(8'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) < 7), 4'($urandom), ir, ov);
    end
    cyc4(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, ir, ov);
    cyc4(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, ir, ov);
    chk("final_empty", {28'd0, ov}, 32'h0);

    // N=3: out-of-range unicast is taken, dropped and flagged for one cycle.
    if3.in_sel = 2'd3; if3.in_bcast = 1'b0; if3.in_data = 8'hEE;
    if3.in_valid = 1'b1; if3.out_ready = 3'b111;
    @(negedge clk);
    chk("n3_bad_ready", {31'd0, if3.in_ready}, 32'h1);
    chk("n3_err_before", {31'd0, if3.sel_err}, 32'h0);
    @(posedge clk);
    #1;
    if3.in_valid = 1'b0;
    @(negedge clk);
    chk("n3_err_pulse", {31'd0, if3.sel_err}, 32'h1);
    chk("n3_no_load", {29'd0, if3.out_valid}, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("n3_err_clear", {31'd0, if3.sel_err}, 32'h0);
    @(posedge clk);
    #1;
    // Broadcast ignores the out-of-range select and raises no error.
    if3.in_bcast = 1'b1; if3.in_data = 8'h5C; if3.in_valid = 1'b1;
    @(negedge clk);
    chk("n3_bcast_ready", {31'd0, if3.in_ready}, 32'h1);
    @(posedge clk);
    #1;
    if3.in_valid = 1'b0;
    @(negedge clk);
    chk("n3_bcast_valid", {29'd0, if3.out_valid}, 32'h7);
    chk("n3_bcast_data", {8'd0, if3.out_data}, 32'h5C5C5C);
    chk("n3_bcast_no_err", {31'd0, if3.sel_err}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
